// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer driving one external 1-bit ALU slice through a WIDTH-bit
// operation, LSB first; SLT takes a second pass through the slice's less path.
module alu_serial_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero,
   output logic             slice_ai,
   output logic             slice_bi,
   output logic             slice_cin,
   output logic             slice_lessi,
   output logic             slice_aluop0,
   output logic             slice_aluop1,
   output logic             slice_aluop2,
   input  logic             slice_outp,
   input  logic             slice_cout
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PASS1 = 2'd1,
      PASS2 = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state_r;
   logic [CW-1:0]    cnt_r;
   logic [WIDTH-1:0] sa_r;
   logic [WIDTH-1:0] sb_r;
   logic [WIDTH-1:0] asave_r;
   logic [WIDTH-1:0] bsave_r;
   logic [WIDTH-1:0] rsh_r;
   logic [WIDTH-1:0] result_r;
   logic [2:0]       op_r;
   logic             cout_r;
   logic             set_r;
   logic             carry_r;
   logic             zero_r;
   logic             done_r;
   logic             in_ready_r;

   logic             last_bit_s;
   logic             first_bit_s;
   logic [WIDTH-1:0] rnext_s;

   function automatic logic is_zero(input logic [WIDTH-1:0] v);
      return (v == {WIDTH{1'b0}});
   endfunction

   assign last_bit_s  = (cnt_r == CW'(WIDTH - 1));
   assign first_bit_s = (cnt_r == {CW{1'b0}});
   assign rnext_s     = {slice_outp, rsh_r[WIDTH-1:1]};

   assign in_ready = in_ready_r;
   assign done     = done_r;
   assign result   = result_r;
   assign carry    = carry_r;
   assign zero     = zero_r;

   // Slice drive: operand bits, carry-in chain and opcode per pass; idle drives all zeros.
   always_comb begin
      slice_ai     = 1'b0;
      slice_bi     = 1'b0;
      slice_cin    = 1'b0;
      slice_lessi  = 1'b0;
      slice_aluop0 = 1'b0;
      slice_aluop1 = 1'b0;
      slice_aluop2 = 1'b0;
      case (state_r)
         PASS1: begin
            slice_ai  = sa_r[0];
            slice_bi  = sb_r[0];
            slice_cin = first_bit_s ? op_r[2] : cout_r;
            // SLT's first pass is a plain subtract to obtain the sign of A-B
            if (op_r == 3'b111) begin
               {slice_aluop2, slice_aluop1, slice_aluop0} = 3'b101;
            end else begin
               {slice_aluop2, slice_aluop1, slice_aluop0} = op_r;
            end
         end
         PASS2: begin
            slice_ai    = sa_r[0];
            slice_bi    = sb_r[0];
            slice_cin   = first_bit_s ? op_r[2] : cout_r;
            slice_lessi = first_bit_s ? set_r : 1'b0;
            {slice_aluop2, slice_aluop1, slice_aluop0} = 3'b111;
         end
         default: begin
            slice_ai = 1'b0;
         end
      endcase
   end

   // Sequencer state, operand shifters, result assembly and registered status.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         cnt_r      <= {CW{1'b0}};
         sa_r       <= {WIDTH{1'b0}};
         sb_r       <= {WIDTH{1'b0}};
         asave_r    <= {WIDTH{1'b0}};
         bsave_r    <= {WIDTH{1'b0}};
         rsh_r      <= {WIDTH{1'b0}};
         result_r   <= {WIDTH{1'b0}};
         op_r       <= 3'b000;
         cout_r     <= 1'b0;
         set_r      <= 1'b0;
         carry_r    <= 1'b0;
         zero_r     <= 1'b0;
         done_r     <= 1'b0;
         in_ready_r <= 1'b1;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  sa_r       <= a;
                  sb_r       <= b;
                  asave_r    <= a;
                  bsave_r    <= b;
                  op_r       <= op;
                  cnt_r      <= {CW{1'b0}};
                  in_ready_r <= 1'b0;
                  state_r    <= PASS1;
               end else begin
                  in_ready_r <= 1'b1;
               end
            end
            PASS1, PASS2: begin
               rsh_r  <= rnext_s;
               sa_r   <= {1'b0, sa_r[WIDTH-1:1]};
               sb_r   <= {1'b0, sb_r[WIDTH-1:1]};
               cout_r <= slice_cout;
               if (last_bit_s) begin
                  cnt_r <= {CW{1'b0}};
                  if ((state_r == PASS1) && (op_r == 3'b111)) begin
                     carry_r <= slice_cout;
                     set_r   <= slice_outp;
                     sa_r    <= asave_r;
                     sb_r    <= bsave_r;
                     state_r <= PASS2;
                  end else begin
                     // pass-1 carry survives the SLT second pass untouched
                     if (state_r == PASS1) begin
                        carry_r <= slice_cout;
                        set_r   <= slice_outp;
                     end else begin
                        set_r <= set_r;
                     end
                     result_r <= rnext_s;
                     zero_r   <= is_zero(rnext_s);
                     done_r   <= 1'b1;
                     state_r  <= DONE;
                  end
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            DONE: begin
               in_ready_r <= 1'b1;
               state_r    <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed bench for alu_serial_seq with a behavioural 1-bit ALU slice model.
module tb_alu_serial_seq;

   localparam int W = 32;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic [2:0]    op;
   logic          done;
   logic [W-1:0]  result;
   logic          carry;
   logic          zero;
   logic          slice_ai, slice_bi, slice_cin, slice_lessi;
   logic          slice_aluop0, slice_aluop1, slice_aluop2;
   logic          slice_outp, slice_cout;
   logic          bb;

   int total_cnt = 0;
   int pass_cnt  = 0;

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         carry;
      logic         zero;
   } vec_t;

   vec_t vecs[8];

   alu_serial_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .done(done), .result(result), .carry(carry), .zero(zero),
      .slice_ai(slice_ai), .slice_bi(slice_bi), .slice_cin(slice_cin),
      .slice_lessi(slice_lessi), .slice_aluop0(slice_aluop0),
      .slice_aluop1(slice_aluop1), .slice_aluop2(slice_aluop2),
      .slice_outp(slice_outp), .slice_cout(slice_cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Classic 1-bit ALU slice: aluop2 inverts B, {aluop1,aluop0} picks AND/ADD/OR/less.
   always_comb begin
      bb         = slice_bi ^ slice_aluop2;
      slice_cout = (slice_ai & bb) | (slice_ai & slice_cin) | (bb & slice_cin);
      case ({slice_aluop1, slice_aluop0})
         2'b00:   slice_outp = slice_ai & bb;
         2'b01:   slice_outp = slice_ai ^ bb ^ slice_cin;
         2'b10:   slice_outp = slice_ai | bb;
         default: slice_outp = slice_lessi;
      endcase
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end else begin
         pass_cnt++;
      end
   endtask

   function automatic logic [6:0] slice_bus();
      return {slice_ai, slice_bi, slice_cin, slice_lessi, slice_aluop2, slice_aluop1, slice_aluop0};
   endfunction

   // Leaves the bench on a falling edge with in_ready high (or reports a timeout).
   task automatic wait_ready();
      bit got;
      got = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (in_ready) begin
            got = 1'b1;
            break;
         end
      end
      chk("ready_wait", {31'd0, got}, 32'd1);
   endtask

   task automatic run_vec(input vec_t v);
      int         lat;
      int         ndone;
      int         explat;
      bit         aluop_ok, lessi_ok, rdy_ok;
      logic [2:0] exp_op;
      logic       exp_less;
      explat = (v.op == 3'b111) ? 2 * W + 1 : W + 1;
      wait_ready();
      in_valid = 1'b1; op = v.op; a = v.a; b = v.b;
      @(posedge clk);
      #1;
      in_valid = 1'b0; op = 3'b001; a = 32'hDEADBEEF; b = 32'h13579BDF;
      lat = 0; ndone = 0; aluop_ok = 1'b1; lessi_ok = 1'b1; rdy_ok = 1'b1;
      for (int n = 1; n <= 2 * W + 6; n++) begin
         @(negedge clk);
         if (n <= W)
            exp_op = (v.op == 3'b111) ? 3'b101 : v.op;
         else if ((v.op == 3'b111) && (n <= 2 * W))
            exp_op = 3'b111;
         else
            exp_op = 3'b000;
         if ({slice_aluop2, slice_aluop1, slice_aluop0} !== exp_op) aluop_ok = 1'b0;
         exp_less = ((v.op == 3'b111) && (n == W + 1)) ? v.res[0] : 1'b0;
         if (slice_lessi !== exp_less) lessi_ok = 1'b0;
         if (n == 1) chk("cin_bit0", {31'd0, slice_cin}, {31'd0, v.op[2]});
         if ((v.op == 3'b111) && (n == W + 1))
            chk("cin_pass2_bit0", {31'd0, slice_cin}, 32'd1);
         if (done) begin
            ndone++;
            if (lat == 0) lat = n;
         end
         if (n <= explat && in_ready) rdy_ok = 1'b0;
         if (n == explat + 1) begin
            chk("ready_after", {31'd0, in_ready}, 32'd1);
            break;
         end
      end
      chk("latency", lat, explat);
      chk("done_pulses", ndone, 1);
      chk("aluop_seq", {31'd0, aluop_ok}, 32'd1);
      chk("lessi_seq", {31'd0, lessi_ok}, 32'd1);
      chk("ready_low", {31'd0, rdy_ok}, 32'd1);
      chk("result", result, v.res);
      chk("carry", {31'd0, carry}, {31'd0, v.carry});
      chk("zero", {31'd0, zero}, {31'd0, v.zero});
   endtask

   initial begin
      vecs[0] = '{op: 3'b001, a: 32'hFFFFFFFF, b: 32'h00000001, res: 32'h00000000, carry: 1'b1, zero: 1'b1};
      vecs[1] = '{op: 3'b101, a: 32'h00000005, b: 32'h00000007, res: 32'hFFFFFFFE, carry: 1'b0, zero: 1'b0};
      vecs[2] = '{op: 3'b111, a: 32'hFFFFFFFD, b: 32'h00000002, res: 32'h00000001, carry: 1'b1, zero: 1'b0};
      vecs[3] = '{op: 3'b111, a: 32'h00000002, b: 32'hFFFFFFFD, res: 32'h00000000, carry: 1'b0, zero: 1'b1};
      vecs[4] = '{op: 3'b000, a: 32'hF0F0A5A5, b: 32'hFF00FF00, res: 32'hF000A500, carry: 1'b1, zero: 1'b0};
      vecs[5] = '{op: 3'b010, a: 32'hF0F0A5A5, b: 32'hFF00FF00, res: 32'hFFF0FFA5, carry: 1'b1, zero: 1'b0};
      vecs[6] = '{op: 3'b011, a: 32'h80000000, b: 32'h80000000, res: 32'h00000000, carry: 1'b1, zero: 1'b1};
      vecs[7] = '{op: 3'b100, a: 32'hFF00FF00, b: 32'h0F0F0F0F, res: 32'hF000F000, carry: 1'b1, zero: 1'b0};

      rst_n = 1'b0; in_valid = 1'b1; a = 32'h0000_0001; b = 32'h0000_0002; op = 3'b001;
      repeat (3) @(negedge clk);
      chk("rst_result", result, 32'h0);
      chk("rst_carry", {31'd0, carry}, 32'd0);
      chk("rst_zero", {31'd0, zero}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_slice", {25'd0, slice_bus()}, 32'd0);
      in_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", {31'd0, in_ready}, 32'd1);

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // Back-to-back: in_valid held, operands changed right after the first accept.
      begin
         int d1, d2;
         bit rdy_ok;
         d1 = 0; d2 = 0; rdy_ok = 1'b1;
         wait_ready();
         in_valid = 1'b1; op = 3'b001; a = 32'd1; b = 32'd2;
         @(posedge clk);
         #1;
         a = 32'd3; b = 32'd4;
         for (int n = 1; n <= 70; n++) begin
            @(negedge clk);
            if (n <= W + 1 && in_ready) rdy_ok = 1'b0;
            if (n == W + 2) chk("b2b_ready34", {31'd0, in_ready}, 32'd1);
            if (n == W + 3) in_valid = 1'b0;
            if (done) begin
               if (d1 == 0) begin
                  d1 = n;
                  chk("b2b_res1", result, 32'd3);
               end else begin
                  d2 = n;
                  chk("b2b_res2", result, 32'd7);
               end
            end
         end
         chk("b2b_ready_low", {31'd0, rdy_ok}, 32'd1);
         chk("b2b_done1", d1, W + 1);
         chk("b2b_done2", d2, 2 * W + 3);
      end

      // Reset in cycle 10 of an ADD aborts it with no done pulse.
      begin
         int nd;
         nd = 0;
         wait_ready();
         in_valid = 1'b1; op = 3'b001; a = 32'h12345678; b = 32'h00000001;
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         for (int n = 1; n <= 10; n++) @(negedge clk);
         rst_n = 1'b0;
         @(negedge clk);
         chk("mid_rst_result", result, 32'h0);
         chk("mid_rst_slice", {25'd0, slice_bus()}, 32'd0);
         chk("mid_rst_done", {31'd0, done}, 32'd0);
         rst_n = 1'b1;
         @(negedge clk);
         chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
         for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) nd++;
         end
         chk("mid_rst_no_done", nd, 0);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/alu_serial_seq.md
# alu_serial_seq

Bit-serial sequencer that drives one 1-bit ALU slice to compute a full 32-bit operation. Each cycle it presents one operand bit pair to the slice, captures the sum/logic bit and carry back, and assembles the result LSB-first. SLT uses a second pass through the slice's `less` path. It sits between the datapath's operand/op registers and a single external `ALU_1Bit` slice. It trades 32–64 cycles of latency for one slice's worth of area.

## Interface

Parameters:
- `WIDTH`, 32: operand and result width. Must be a power of two, at least 4.

Ports:
- `clk`, in, 1: the only clock; rising edge.
- `rst_n`, in, 1: synchronous active-low reset, sampled on the rising edge of `clk`.
- `in_valid`, in, 1: operands and op are presented.
- `in_ready`, out, 1: high only in IDLE. Accept occurs when `in_valid` and `in_ready` are both high.
- `a`, in, WIDTH: operand A.
- `b`, in, WIDTH: operand B.
- `op`, in, 3: {aluop2, aluop1, aluop0}.
  - 000 AND, 001 ADD, 010 OR, 101 SUB, 111 SLT.
  - Other codes are executed literally (see Operation).
- `done`, out, 1: one-cycle pulse when `result` and the flags are valid.
- `result`, out, WIDTH: registered result. Held until the next accept.
- `carry`, out, 1: `slice_cout` of the MSB in pass 1. Held with `result`.
- `zero`, out, 1: high when `result` is 0. Held with `result`.
- `slice_ai`, `slice_bi`, `slice_cin`, `slice_lessi`, out, 1 each: drive the slice.
- `slice_aluop0`, `slice_aluop1`, `slice_aluop2`, out, 1 each: drive the slice.
- `slice_outp`, `slice_cout`, in, 1 each: slice outputs, combinational in the same cycle.

## Operation

States: IDLE, PASS1, PASS2, DONE.

- **IDLE**
  - `in_ready` = 1.
  - All `slice_*` outputs are 0.
  - On accept: latch `a` and `b` into shift registers `sa` and `sb`, latch `op`, clear the bit counter to 0, go to PASS1.
- **PASS1**, one bit per cycle, bit i = counter value:
  - `slice_ai` = `sa[0]`; `slice_bi` = `sb[0]`.
  - `slice_aluop*` = latched `op`, except that for SLT the sequencer drives 101 (subtract).
  - `slice_cin`:
    - bit 0: the latched `op[2]`.
    - bits above 0: the registered `slice_cout` from the previous cycle.
  - `slice_lessi` = 0.
  - Each edge:
    - shift `slice_outp` into the result shift register from the MSB end;
    - shift `sa` and `sb` right by 1;
    - register `slice_cout`;
    - increment the counter.
  - At bit WIDTH-1:
    - capture `carry` = `slice_cout`;
    - capture `set` = `slice_outp` (the sign of A−B);
    - if `op` = 111, reload `sa`/`sb` from the saved copies and go to PASS2;
    - otherwise go to DONE.
- **PASS2**, SLT only, WIDTH cycles:
  - `slice_aluop*` = 111.
  - `slice_lessi` = `set` at bit 0, 0 at all other bits.
  - `slice_cin` is generated exactly as in PASS1.
  - `slice_outp` is shifted into the result shift register as in PASS1, so the result is `{0…0, set}`.
  - Pass-1 `carry` is retained.
  - After bit WIDTH-1, go to DONE.
- **DONE**
  - `done` = 1 for exactly one cycle.
  - `in_ready` = 0.
  - Next state is IDLE.
- `result`, `carry` and `zero` update on the final edge of the last pass. They are stable from DONE until the next accept.
- Overflow is not detected. SLT is defined as the sign bit of the wrapped A−B.
- Undefined op codes (011, 100, 110) take a single pass with `slice_aluop*` driven verbatim and `slice_lessi` = 0. The result is whatever the slice produces.

## Timing

- The accept edge ends cycle 0.
- Single-pass ops:
  - PASS1 occupies cycles 1..WIDTH;
  - `done` is high in cycle WIDTH+1 (cycle 33 for WIDTH=32);
  - `in_ready` is high again in cycle WIDTH+2.
- SLT:
  - PASS2 occupies cycles WIDTH+1..2·WIDTH;
  - `done` is high in cycle 2·WIDTH+1 (cycle 65).
- Throughput: with `in_valid` held high, the next accept is in cycle WIDTH+2 (single-pass) or 2·WIDTH+2 (SLT).
- `in_valid` outside IDLE is ignored. Operand changes after accept have no effect.
- Reset, which wins over every other event including accept:
  - state goes to IDLE;
  - counter, `sa`, `sb`, `result`, `carry`, `zero` and `done` are all 0; `zero` resets to 0, not 1;
  - all `slice_*` outputs are 0;
  - `in_ready` is 1 in the first cycle after reset is released.
- Reset during PASS1, PASS2 or DONE aborts the operation. No `done` pulse is produced for the aborted operation.
- Bit-counter wrap from WIDTH-1 to 0 coincides with the state transition. The counter never reaches WIDTH.

## Test plan

- **ADD wrap:** ADD a=0xFFFFFFFF, b=0x00000001 → `done` in cycle 33, `result`=0x00000000, `carry`=1, `zero`=1.
- **SUB borrow:** SUB a=5, b=7 → `result`=0xFFFFFFFE, `carry`=0, `zero`=0. Also check `slice_cin`=1 at bit 0 and `slice_aluop*`=101 throughout.
- **SLT both signs:**
  - SLT a=0xFFFFFFFD (−3), b=2 → `result`=0x00000001, `done` in cycle 65, `slice_lessi`=1 only in cycle 33.
  - SLT a=2, b=−3 → `result`=0x00000000, `zero`=1.
- **Logic ops:**
  - AND a=0xF0F0A5A5, b=0xFF00FF00 → 0xF000A500.
  - OR with the same operands → 0xFFF0FFA5.
  - For both, `slice_cin` follows `op[2]` at bit 0 and `carry` is captured as produced.
- **Back-to-back:** `in_valid` held high with ADD 1+2, then ADD 3+4 → results 3 and 7. Second accept in cycle 34; second `done` in cycle 67; `in_ready`=0 from cycle 1 to cycle 33.
- **Reset mid-run:** ADD started; `rst_n`=0 in cycle 10 → next cycle `result`=0, all `slice_*`=0, `done` never pulses, `in_ready`=1 after `rst_n` returns high.
